// File: rtl/rv32_muldiv_pkg.sv
// Shared encodings for the RV32M execute unit: funct3 op codes, FSM states,
// divide special-case constants and the multiply product helper.
package rv32_muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;
  localparam logic [31:0] OVF_QUO  = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // 33x33 signed product; only the low 64 bits are ever needed.
  function automatic logic [31:0] mul_result(input logic [2:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [32:0] sa;
    logic signed [32:0] sb;
    logic signed [63:0] p;
    sa = {(op != OP_MULHU) & a[31], a};
    sb = {(op == OP_MULH)  & b[31], b};
    p  = 64'(sa) * 64'(sb);
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

endpackage

// File: rtl/rv32_divider.sv
// Iterative restoring divider on unsigned magnitudes; retires DIV_BITS
// quotient bits per clock and pulses done_o after the last iteration.
module rv32_divider #(
  parameter int DIV_BITS = 1
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o,
  output logic        done_o
);
  localparam int ITERS = 32 / DIV_BITS;
  localparam int CW    = $clog2(ITERS + 1);

  logic [31:0]   rem_q, rem_d;
  logic [31:0]   quo_q, quo_d;
  logic [31:0]   dvs_q;
  logic [CW-1:0] cnt_q;
  logic          done_q;

  always_comb begin
    logic [32:0] trial;
    trial = '0;
    rem_d = rem_q;
    quo_d = quo_q;
    for (int i = 0; i < DIV_BITS; i++) begin
      trial = {rem_d, quo_d[31]};
      quo_d = {quo_d[30:0], 1'b0};
      if (trial >= {1'b0, dvs_q}) begin
        trial    = trial - {1'b0, dvs_q};
        quo_d[0] = 1'b1;
      end
      rem_d = trial[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (kill_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= '0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= CW'(ITERS);
      done_q <= 1'b0;
    end else if (cnt_q != '0) begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_q - CW'(1);
      done_q <= (cnt_q == CW'(1));
    end else begin
      done_q <= 1'b0;
    end
  end

  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;
  assign done_o      = done_q;
endmodule

// File: rtl/rv32_muldiv.sv
// RV32M execute unit: pipelined multiply, iterative divide, one op in flight,
// registered result held in DONE while the hazard unit stalls.
module rv32_muldiv
  import rv32_muldiv_pkg::*;
#(
  parameter int MUL_LATENCY   = 2,
  parameter int DIV_BITS      = 1,
  parameter int EARLY_DIV_OUT = 1
) (
  input  logic        clk,
  input  logic        reset_,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic [2:0]  op_in,
  input  logic [31:0] rs1_value_in,
  input  logic [31:0] rs2_value_in,
  input  logic [4:0]  rd_in,
  output logic        busy_out,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic [31:0] result_out
);
  localparam int NP = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;

  state_t                 state_q;
  logic [2:0]             op_q;
  logic [31:0]            a_q, b_q;
  logic [4:0]             rd_q, rd_out_q;
  logic                   qneg_q, rneg_q, divz_q, ovf_q;
  logic [MUL_LATENCY-1:0] mul_vld_q;
  logic [NP-1:0][31:0]    prod_q;
  logic                   valid_q;
  logic [31:0]            result_q;

  logic        accept, in_div, in_uns, s1, s2, divz_in, ovf_in, div_start;
  logic [31:0] mag1, mag2, mul_sel, mul_fin;
  logic [31:0] dq, dr, quo, rem, div_res;
  logic        div_done, div_fin;

  assign accept  = valid_in && !stall_in && !flush_in &&
                   (state_q == ST_IDLE || state_q == ST_DONE);
  assign in_div  = (op_in >= OP_DIV);
  assign in_uns  = (op_in == OP_DIVU) || (op_in == OP_REMU);
  assign s1      = !in_uns && rs1_value_in[31];
  assign s2      = !in_uns && rs2_value_in[31];
  assign mag1    = s1 ? -rs1_value_in : rs1_value_in;
  assign mag2    = s2 ? -rs2_value_in : rs2_value_in;
  assign divz_in = (rs2_value_in == '0);
  assign ovf_in  = !in_uns && rs1_value_in == OVF_QUO && rs2_value_in == DIV0_QUO;
  // Special cases skip the iteration entirely when the early exit is enabled.
  assign div_start = accept && in_div && !((EARLY_DIV_OUT != 0) && (divz_in || ovf_in));

  rv32_divider #(.DIV_BITS(DIV_BITS)) u_div (
    .clk        (clk),
    .reset_     (reset_),
    .start_i    (div_start),
    .kill_i     (flush_in),
    .dividend_i (mag1),
    .divisor_i  (mag2),
    .quotient_o (dq),
    .remainder_o(dr),
    .done_o     (div_done)
  );

  assign mul_sel = mul_result(op_q, a_q, b_q);
  assign mul_fin = (MUL_LATENCY == 1) ? mul_sel : prod_q[NP-1];

  generate
    if (MUL_LATENCY > 1) begin : g_pipe
      always_ff @(posedge clk) begin
        if (!reset_) begin
          prod_q <= '0;
        end else begin
          prod_q[0] <= mul_sel;
          for (int i = 1; i < NP; i++) prod_q[i] <= prod_q[i-1];
        end
      end
    end else begin : g_nopipe
      assign prod_q = '0;
    end
  endgenerate

  always_comb begin
    quo = qneg_q ? -dq : dq;
    rem = rneg_q ? -dr : dr;
    if (divz_q) begin
      quo = DIV0_QUO;
      rem = a_q;
    end else if (ovf_q) begin
      quo = OVF_QUO;
      rem = '0;
    end
    div_res = op_q[1] ? rem : quo;
  end

  assign div_fin = ((EARLY_DIV_OUT != 0) && (divz_q || ovf_q)) || div_done;

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      divz_q    <= 1'b0;
      ovf_q     <= 1'b0;
      mul_vld_q <= '0;
      valid_q   <= 1'b0;
      rd_out_q  <= '0;
      result_q  <= '0;
    end else if (flush_in) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      mul_vld_q <= '0;
    end else begin
      mul_vld_q <= mul_vld_q << 1;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (!(state_q == ST_DONE && stall_in)) begin
            valid_q <= 1'b0;
            state_q <= ST_IDLE;
            if (accept) begin
              op_q      <= op_in;
              a_q       <= rs1_value_in;
              b_q       <= rs2_value_in;
              rd_q      <= rd_in;
              qneg_q    <= s1 ^ s2;
              rneg_q    <= s1;
              divz_q    <= in_div && divz_in;
              ovf_q     <= in_div && ovf_in;
              state_q   <= in_div ? ST_DIV : ST_MUL;
              mul_vld_q <= in_div ? '0 : MUL_LATENCY'(1);
            end
          end
        end
        ST_MUL: begin
          if (mul_vld_q[MUL_LATENCY-1]) begin
            result_q <= mul_fin;
            rd_out_q <= rd_q;
            valid_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DIV: begin
          if (div_fin) begin
            result_q <= div_res;
            rd_out_q <= rd_q;
            valid_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_out   = (state_q == ST_MUL) || (state_q == ST_DIV) ||
                      (state_q == ST_DONE && stall_in);
  assign valid_out  = valid_q;
  assign rd_out     = rd_out_q;
  assign result_out = result_q;
endmodule

// File: tb/tb_rv32_muldiv.sv
// Directed + scoreboarded bench for rv32_muldiv: a default instance
// (latency 2, radix 2, early exit) and a latency-4 / radix-16 / no-early one.
module tb_rv32_muldiv;
  import rv32_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, vin = 1'b0, v4in = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic [4:0]  rd = '0;
  logic        busy, vout, busy4, vout4;
  logic [4:0]  rdo, rdo4;
  logic [31:0] reso, reso4;

  always #5 clk = ~clk;

  rv32_muldiv #(.MUL_LATENCY(2), .DIV_BITS(1), .EARLY_DIV_OUT(1)) u_dut (
    .clk(clk), .reset_(reset_), .stall_in(stall), .flush_in(flush),
    .valid_in(vin), .op_in(op), .rs1_value_in(rs1), .rs2_value_in(rs2),
    .rd_in(rd), .busy_out(busy), .valid_out(vout), .rd_out(rdo),
    .result_out(reso));

  rv32_muldiv #(.MUL_LATENCY(4), .DIV_BITS(4), .EARLY_DIV_OUT(0)) u_dut4 (
    .clk(clk), .reset_(reset_), .stall_in(stall), .flush_in(flush),
    .valid_in(v4in), .op_in(op), .rs1_value_in(rs1), .rs2_value_in(rs2),
    .rd_in(rd), .busy_out(busy4), .valid_out(vout4), .rd_out(rdo4),
    .result_out(reso4));

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic o_vld(input int w);  return w != 0 ? vout4 : vout; endfunction
  function automatic logic o_busy(input int w); return w != 0 ? busy4 : busy; endfunction
  function automatic logic [31:0] o_res(input int w); return w != 0 ? reso4 : reso; endfunction
  function automatic logic [4:0]  o_rd(input int w);  return w != 0 ? rdo4 : rdo; endfunction

  // Independent reference for RV32M results (truncating division, RISC-V specials).
  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb2, p;
    longint unsigned pu;
    int ia, ib;
    sa = longint'($signed(a));
    sb2 = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      3'd0: begin p = sa * sb2; return p[31:0]; end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  // Caller is at a negedge; the op is accepted at the following posedge.
  task automatic drive(input int w, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r,
                       input logic [31:0] e, input int lat);
    op = o; rs1 = a; rs2 = b; rd = r;
    if (w != 0) v4in = 1'b1; else vin = 1'b1;
    sb.push_back('{e, r, lat});
  endtask

  // n counts posedges after the accept edge until valid_out is seen.
  task automatic await(input int w, input string tag);
    int n;
    bit busy_ok;
    exp_t x;
    n = 0;
    busy_ok = 1'b1;
    @(negedge clk);
    vin = 1'b0; v4in = 1'b0;
    while (!o_vld(w) && n < 100) begin
      if (!o_busy(w)) busy_ok = 1'b0;
      @(negedge clk);
      n++;
    end
    x = sb.pop_front();
    chk({tag, " valid"}, 32'(o_vld(w)), 32'd1);
    chk({tag, " result"}, o_res(w), x.res);
    chk({tag, " rd"}, 32'(o_rd(w)), 32'(x.rd));
    chk({tag, " latency"}, 32'(n), 32'(x.lat));
    chk({tag, " busy"}, 32'(busy_ok), 32'd1);
  endtask

  task automatic run(input int w, input string tag, input logic [2:0] o,
                     input logic [31:0] a, input logic [31:0] b, input logic [4:0] r,
                     input logic [31:0] e, input int lat);
    @(negedge clk);
    drive(w, o, a, b, r, e, lat);
    await(w, tag);
  endtask

  initial begin
    int n, late, lat;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    logic [4:0] rr;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst valid", 32'(vout), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst result", reso, 32'd0);
    chk("rst rd", 32'(rdo), 32'd0);
    reset_ = 1'b1;

    // Multiply, latency 2
    run(0, "mul 7*6", OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 2);
    run(0, "mulh -1*-1", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'h0, 2);
    run(0, "mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, 2);
    run(0, "mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, 2);
    run(0, "mul rd0", OP_MUL, 32'h0001_0000, 32'h0001_0001, 5'd0, 32'h0001_0000, 2);

    // Divide, 33-cycle latency
    run(0, "div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 33);
    run(0, "rem -7/2", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 33);
    run(0, "divu 100/7", OP_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, 33);
    run(0, "remu 100/7", OP_REMU, 32'd100, 32'd7, 5'd12, 32'd2, 33);

    // Special cases, early exit
    run(0, "divu 5/0", OP_DIVU, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    run(0, "rem 5/0", OP_REM, 32'd5, 32'd0, 5'd14, 32'd5, 1);
    run(0, "div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    run(0, "rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0, 1);

    // Stall held across divide completion, then back-to-back multiply
    @(negedge clk);
    drive(0, OP_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, 33);
    @(negedge clk);
    vin = 1'b0; stall = 1'b1; n = 0;
    while (!vout && n < 100) begin @(negedge clk); n++; end
    begin
      exp_t x;
      x = sb.pop_front();
      chk("stall div result", reso, x.res);
      chk("stall div latency", 32'(n), 32'(x.lat));
    end
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      chk("stall hold valid", 32'(vout), 32'd1);
      chk("stall hold result", reso, 32'd14);
      chk("stall hold rd", 32'(rdo), 32'd17);
      chk("stall hold busy", 32'(busy), 32'd1);
    end
    stall = 1'b0;
    drive(0, OP_MUL, 32'd11, 32'd13, 5'd18, 32'd143, 2);
    await(0, "b2b mul");

    // Flush mid-divide, then immediate multiply
    @(negedge clk);
    op = OP_DIV; rs1 = 32'd1000; rs2 = 32'd3; rd = 5'd19; vin = 1'b1;
    @(negedge clk);
    vin = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    op = OP_MUL; rs1 = 32'd5; rs2 = 32'd9; rd = 5'd20; vin = 1'b1;
    @(negedge clk);
    chk("flush busy", 32'(busy), 32'd0);
    chk("flush valid", 32'(vout), 32'd0);
    flush = 1'b0;
    sb.push_back('{32'd45, 5'd20, 2});
    await(0, "post-flush mul");
    late = 0;
    repeat (40) begin @(negedge clk); if (vout) late++; end
    chk("flush no late valid", 32'(late), 32'd0);

    // Model-checked random operations
    for (int i = 0; i < 10; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 5 == 0) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom);
      rr = 5'($urandom_range(1, 31));
      if (!ro[2]) lat = 2;
      else if (rb == 0 || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF)) lat = 1;
      else lat = 33;
      run(0, "rand", ro, ra, rb, rr, model(ro, ra, rb), lat);
    end

    // Latency-4 multiply, radix-16 divide, specials take the full count
    run(1, "l4 mul", OP_MUL, 32'd7, 32'd6, 5'd5, 32'd42, 4);
    run(1, "r16 divu", OP_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 9);
    run(1, "r16 div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, 9);
    run(1, "r16 rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 9);
    run(1, "r16 divu/0", OP_DIVU, 32'd5, 32'd0, 5'd7, 32'hFFFF_FFFF, 9);
    run(1, "r16 rem ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h0, 9);
    run(1, "r16 div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 9);

    // Reset mid-multiply on the latency-4 instance
    @(negedge clk);
    op = OP_MUL; rs1 = 32'd3; rs2 = 32'd3; rd = 5'd21; v4in = 1'b1;
    @(negedge clk);
    v4in = 1'b0;
    @(negedge clk);
    reset_ = 1'b0;
    @(negedge clk);
    chk("midrst valid", 32'(vout4), 32'd0);
    chk("midrst busy", 32'(busy4), 32'd0);
    chk("midrst result", reso4, 32'd0);
    chk("midrst rd", 32'(rdo4), 32'd0);
    reset_ = 1'b1;
    late = 0;
    repeat (8) begin @(negedge clk); if (vout4) late++; end
    chk("midrst no late valid", 32'(late), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
